// File: rtl/sort_result_checker_pkg.sv
// Shared definitions for the sorter result checker: default geometry and FSM state encoding.
// The state values match the encoding used by the sorter and the stimulus harness.
package sort_result_checker_pkg;

  localparam int DEF_P_LOG   = 7;
  localparam int DEF_DATW    = 64;
  localparam int DEF_KEYW    = 32;
  localparam int DEF_LATW    = 16;
  localparam int DEF_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SCAN = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/sort_result_checker_rec_cmp.sv
// Combinational per-record check: flags a record whose key is out of sequence,
// whose payload is not all ones, or whose key drops below the previous key.
module sort_rec_cmp #(
  parameter int P_LOG = 7,
  parameter int DATW  = 64,
  parameter int KEYW  = 32
) (
  input  logic [DATW-1:0]  rec,
  input  logic [KEYW-1:0]  prev_key,
  input  logic [P_LOG-1:0] idx,
  output logic             fail
);

  logic [KEYW-1:0]      key;
  logic [DATW-KEYW-1:0] payload;
  logic [KEYW-1:0]      exp_key;
  logic                 bad_key;
  logic                 bad_payload;
  logic                 descending;

  assign key         = rec[KEYW-1:0];
  assign payload     = rec[DATW-1:KEYW];
  // Expected key is idx+1, widened before the add so idx = N-1 yields N.
  assign exp_key     = KEYW'(idx) + KEYW'(1);
  assign bad_key     = (key != exp_key);
  assign bad_payload = (payload != {(DATW-KEYW){1'b1}});
  assign descending  = (idx != '0) && (key < prev_key);
  assign fail        = bad_key | bad_payload | descending;

endmodule

// File: rtl/sort_result_checker.sv
// Consumer end of the bitonic sorter harness: measures START-to-DOTEN latency, then scans
// the captured block one record per cycle and holds a PASS/FAIL verdict until the next START.
module sort_result_checker
  import sort_result_checker_pkg::*;
#(
  parameter int P_LOG   = DEF_P_LOG,
  parameter int DATW    = DEF_DATW,
  parameter int KEYW    = DEF_KEYW,
  parameter int LATW    = DEF_LATW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [(DATW<<P_LOG)-1:0] DOT,
  input  logic                    DOTEN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    PASS,
  output logic                    TMO,
  output logic                    OVR,
  output logic [P_LOG:0]          ERR_CNT,
  output logic [LATW-1:0]         LAT,
  output logic [1:0]              ULED
);

  localparam int N    = 1 << P_LOG;
  localparam int BLKW = DATW << P_LOG;

  state_t            state, next_state;
  logic [BLKW-1:0]   cap;
  logic [KEYW-1:0]   prev_key;
  logic [P_LOG-1:0]  idx;
  logic [P_LOG:0]    err_cnt;
  logic [LATW-1:0]   lat;
  logic              tmo;
  logic              ovr;
  logic              rec_fail;
  logic              timeout_hit;
  logic              last_rec;

  assign timeout_hit = (lat == LATW'(TIMEOUT));
  assign last_rec    = (idx == P_LOG'(N-1));

  sort_rec_cmp #(
    .P_LOG (P_LOG),
    .DATW  (DATW),
    .KEYW  (KEYW)
  ) u_cmp (
    .rec      (cap[DATW-1:0]),
    .prev_key (prev_key),
    .idx      (idx),
    .fail     (rec_fail)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, FIN: if (START) next_state = WAIT;
      // DOTEN takes priority over a timeout landing in the same cycle.
      WAIT: begin
        if (DOTEN)            next_state = SCAN;
        else if (timeout_hit) next_state = FIN;
      end
      SCAN:    if (last_rec) next_state = FIN;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cap      <= '0;
      prev_key <= '0;
      idx      <= '0;
      err_cnt  <= '0;
      lat      <= '0;
      tmo      <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            err_cnt <= '0;
            tmo     <= 1'b0;
            ovr     <= 1'b0;
            lat     <= LATW'(1);
          end
        end
        WAIT: begin
          if (DOTEN) begin
            cap      <= DOT;
            idx      <= '0;
            prev_key <= '0;
          end else if (timeout_hit) begin
            tmo     <= 1'b1;
            err_cnt <= (P_LOG+1)'(N);
          end else begin
            lat <= lat + LATW'(1);
          end
        end
        // Record 0 sits at the LSB; shifting right presents the next record each cycle.
        SCAN: begin
          cap      <= cap >> DATW;
          prev_key <= cap[KEYW-1:0];
          idx      <= idx + P_LOG'(1);
          if (rec_fail && (err_cnt != (P_LOG+1)'(N)))
            err_cnt <= err_cnt + (P_LOG+1)'(1);
          if (DOTEN)
            ovr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY    = (state == WAIT) || (state == SCAN);
  assign DONE    = (state == FIN);
  assign PASS    = DONE && (err_cnt == '0) && !tmo && !ovr;
  assign TMO     = tmo;
  assign OVR     = ovr;
  assign ERR_CNT = err_cnt;
  assign LAT     = lat;
  assign ULED    = {PASS & DONE, DONE};

endmodule
